// File: rtl/la_cmd_pkg.sv
// Shared opcodes, frame constants and sequencer state encoding for the
// LogicAnalyzer2 command sequencer.
package la_cmd_pkg;

  localparam logic [7:0] OP_START    = 8'h01;
  localparam logic [7:0] OP_ABORT    = 8'h02;
  localparam logic [7:0] OP_WR_TRIG  = 8'h03;
  localparam logic [7:0] OP_WR_BUFF  = 8'h04;
  localparam logic [7:0] OP_RD_TRACE = 8'h05;
  localparam logic [7:0] OP_RD_SIZE  = 8'h06;
  localparam logic [7:0] OP_RD_TSAMP = 8'h07;
  localparam logic [7:0] OP_RESET    = 8'h09;
  localparam logic [7:0] OP_RD_BUFF  = 8'h0A;
  localparam logic [7:0] OP_RD_TRIG  = 8'h0B;

  localparam logic [7:0]  ERR_BYTE  = 8'hEE;
  localparam int unsigned FRAME_LEN = 9;

  typedef enum logic [2:0] {
    COLLECT,
    EXEC,
    SEND,
    TREQ,
    TWAIT
  } seq_state_t;

endpackage

// File: rtl/la_tx_serializer.sv
// Byte serializer for 64-bit responses: LSB first, at most one write per two
// cycles, stalls while the TX FIFO reports full. done pulses with the last byte.
module la_tx_serializer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [63:0] load_data,
  input  logic [3:0]  load_cnt,
  input  logic        tx_full,
  output logic [7:0]  tx_data,
  output logic        tx_write,
  output logic        done
);

  logic [63:0] shreg;
  logic [3:0]  cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg    <= '0;
      cnt      <= '0;
      tx_data  <= '0;
      tx_write <= 1'b0;
      done     <= 1'b0;
    end else begin
      tx_write <= 1'b0;
      done     <= 1'b0;
      if (load) begin
        shreg <= load_data;
        cnt   <= load_cnt;
      end else if (cnt != '0 && !tx_full && !tx_write) begin
        tx_data  <= shreg[7:0];
        tx_write <= 1'b1;
        shreg    <= {8'h00, shreg[63:8]};
        cnt      <= cnt - 4'd1;
        done     <= (cnt == 4'd1);
      end
    end
  end

endmodule

// File: rtl/la_cmd_sequencer.sv
// Command sequencer: pops 9-byte frames from the UART RX FIFO, drives capture
// configuration/control, and streams read responses into the UART TX FIFO.
module la_cmd_sequencer
  import la_cmd_pkg::*;
#(
  parameter int unsigned FRAME_TIMEOUT = 1000000,
  parameter int unsigned TO_W          = 20,
  parameter int unsigned TRACE_LEN_W   = 16
) (
  input  logic                   clk,
  input  logic                   btnCpuReset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_data_present,
  output logic                   rx_read,
  output logic [7:0]             tx_data,
  output logic                   tx_write,
  input  logic                   tx_full,
  output logic [63:0]            trig_cfg,
  output logic [63:0]            buff_cfg,
  output logic                   trig_cfg_we,
  output logic                   buff_cfg_we,
  output logic                   cap_start,
  output logic                   cap_abort,
  output logic                   cap_reset,
  input  logic [TRACE_LEN_W-1:0] trace_size,
  input  logic [63:0]            trig_sample,
  output logic                   trace_rd_req,
  input  logic                   trace_rd_valid,
  input  logic [63:0]            trace_rd_data,
  output logic                   busy
);

  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(FRAME_TIMEOUT - 1);
  localparam logic [3:0]      LAST_BYTE = 4'(FRAME_LEN - 1);

  seq_state_t             state;
  logic [3:0]             byte_cnt;
  logic [TO_W-1:0]        to_cnt;
  logic [7:0]             opcode;
  logic [63:0]            payload;
  logic [TRACE_LEN_W-1:0] words;
  logic                   ser_load;
  logic [63:0]            ser_data;
  logic [3:0]             ser_cnt;
  logic                   ser_done;

  assign busy = (state != COLLECT);

  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      state        <= COLLECT;
      byte_cnt     <= '0;
      to_cnt       <= '0;
      opcode       <= '0;
      payload      <= '0;
      words        <= '0;
      ser_load     <= 1'b0;
      ser_data     <= '0;
      ser_cnt      <= '0;
      rx_read      <= 1'b0;
      trig_cfg     <= '0;
      buff_cfg     <= '0;
      trig_cfg_we  <= 1'b0;
      buff_cfg_we  <= 1'b0;
      cap_start    <= 1'b0;
      cap_abort    <= 1'b0;
      cap_reset    <= 1'b0;
      trace_rd_req <= 1'b0;
    end else begin
      rx_read      <= 1'b0;
      trig_cfg_we  <= 1'b0;
      buff_cfg_we  <= 1'b0;
      cap_start    <= 1'b0;
      cap_abort    <= 1'b0;
      cap_reset    <= 1'b0;
      trace_rd_req <= 1'b0;
      ser_load     <= 1'b0;
      unique case (state)
        COLLECT: begin
          rx_read <= rx_data_present && !rx_read;
          // rx_read high means the FIFO head is on rx_data this cycle
          if (rx_read) begin
            to_cnt <= '0;
            if (byte_cnt == '0) opcode <= rx_data;
            else                payload <= {rx_data, payload[63:8]};
            if (byte_cnt == LAST_BYTE) begin
              byte_cnt <= '0;
              state    <= EXEC;
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end else if (byte_cnt != '0) begin
            if (to_cnt == TO_LAST) begin
              byte_cnt <= '0;
              to_cnt   <= '0;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end else begin
            to_cnt <= '0;
          end
        end
        EXEC: begin
          words    <= '0;
          state    <= COLLECT;
          ser_cnt  <= 4'd8;
          case (opcode)
            OP_START:    cap_start <= 1'b1;
            OP_ABORT:    cap_abort <= 1'b1;
            OP_RESET:    cap_reset <= 1'b1;
            OP_WR_TRIG: begin
              trig_cfg    <= payload;
              trig_cfg_we <= 1'b1;
            end
            OP_WR_BUFF: begin
              buff_cfg    <= payload;
              buff_cfg_we <= 1'b1;
            end
            OP_RD_TRACE: begin
              words <= trace_size;
              if (trace_size != '0) state <= TREQ;
            end
            OP_RD_SIZE: begin
              ser_data <= 64'(trace_size);
              ser_load <= 1'b1;
              state    <= SEND;
            end
            OP_RD_TSAMP: begin
              ser_data <= trig_sample;
              ser_load <= 1'b1;
              state    <= SEND;
            end
            OP_RD_BUFF: begin
              ser_data <= buff_cfg;
              ser_load <= 1'b1;
              state    <= SEND;
            end
            OP_RD_TRIG: begin
              ser_data <= trig_cfg;
              ser_load <= 1'b1;
              state    <= SEND;
            end
            default: begin
              ser_data <= 64'(ERR_BYTE);
              ser_cnt  <= 4'd1;
              ser_load <= 1'b1;
              state    <= SEND;
            end
          endcase
        end
        SEND: begin
          if (ser_done) state <= (words != '0) ? TREQ : COLLECT;
        end
        TREQ: begin
          trace_rd_req <= 1'b1;
          state        <= TWAIT;
        end
        TWAIT: begin
          if (trace_rd_valid) begin
            ser_data <= trace_rd_data;
            ser_cnt  <= 4'd8;
            ser_load <= 1'b1;
            words    <= words - TRACE_LEN_W'(1);
            state    <= SEND;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  la_tx_serializer u_ser (
    .clk       (clk),
    .rst_n     (btnCpuReset),
    .load      (ser_load),
    .load_data (ser_data),
    .load_cnt  (ser_cnt),
    .tx_full   (tx_full),
    .tx_data   (tx_data),
    .tx_write  (tx_write),
    .done      (ser_done)
  );

endmodule
